// File: rtl/rf_pkg.sv
// Shared definitions for the register file with scoreboard.
// Holds default sizes, the zero-register constant and the per-bit
// priority order of the scoreboard (flush > reserve > write).
package rf_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

  // Register address type for the default register count. Modules with a
  // non-default NREG declare the same shape locally from their own AW.
  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

  // Architectural zero register: reads 0, ignores writes, never pending.
  localparam int ZERO_REG = 0;

  // Per-bit priority of pending-bit updates, highest value wins.
  // A write and a reserve to the same register leave the bit set because
  // the newly issued producer owns the register from that edge on.
  localparam int unsigned PRIO_FLUSH   = 2;
  localparam int unsigned PRIO_RESERVE = 1;
  localparam int unsigned PRIO_WRITE   = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register marking an
// in-flight producer. Contains next-state priority logic, the registered
// popcount, reservation acceptance and the sticky reservation-error flag.
// No data path lives here.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREG = NREG_DEFAULT,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            flush,
  output logic [NREG-1:0] pend_o,
  output logic            rsv_ok,
  output logic [CW-1:0]   pend_cnt,
  output logic            rsv_err
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            wr_live;
  logic            rsv_zero;

  assign wr_live  = wr_en && (wr_addr != AW'(ZERO_REG));
  assign rsv_zero = (rsv_addr == AW'(ZERO_REG));

  // Reservation is accepted when the target is free, is x0, or is being
  // released by a writeback in this very cycle.
  assign rsv_ok = rsv_zero || !pend_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr));

  // Next pending vector: apply write clear, then reserve set, then flush,
  // so later statements carry the higher priority.
  always_comb begin
    pend_d = pend_q;
    if (wr_live) begin
      pend_d[wr_addr] = 1'b0;
    end
    if (rsv_en && rsv_ok && !rsv_zero) begin
      pend_d[rsv_addr] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  // Sticky error on a dropped reservation; flush clears it and wins over a
  // dropped reserve in the same cycle.
  always_comb begin
    err_d = err_q;
    if (flush) begin
      err_d = 1'b0;
    end else if (rsv_en && !rsv_ok) begin
      err_d = 1'b1;
    end
  end

  // Count is taken from the next-state bits so it always matches pend_q.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CW'(pend_d[i]);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pend_o   = pend_q;
  assign pend_cnt = cnt_q;
  assign rsv_err  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with integrated pending-write scoreboard for decode-stage
// RAW hazard stalls. Synchronous write, NRD combinational read ports.
// Build option RF_BYPASS_EN: when defined, a same-cycle writeback to a read
// port's address is forwarded to that port and clears its busy indication.
module regfile_sb
  import rf_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  parameter  int NREG = NREG_DEFAULT,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  input  logic                flush,
  output logic [CW-1:0]       pend_cnt,
  output logic                rsv_err
);

  typedef logic [AW-1:0] addr_t;

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] pend;
  logic            wr_live;

  assign wr_live = wr_en && (wr_addr != addr_t'(ZERO_REG));

  rf_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .pend_o   (pend),
    .rsv_ok   (rsv_ok),
    .pend_cnt (pend_cnt),
    .rsv_err  (rsv_err)
  );

  // Storage array; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_live) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    addr_t           addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[k*AW +: AW];

    // Read mux for port k; x0 is forced to zero regardless of storage.
    always_comb begin
      data = (addr == addr_t'(ZERO_REG)) ? '0 : mem_q[addr];
      busy = pend[addr];
`ifdef RF_BYPASS_EN
      if (wr_live && (wr_addr == addr)) begin
        data = wr_data;
        busy = 1'b0;
      end
`endif
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = busy;
  end

endmodule
